gbe_tx_packetizer: RTL and testbench

GBE_TX_PACKETIZER -- requirements
Module: gbe_tx_packetizer

---
 rtl/gbe_tx_packetizer.sv | 129 ++++++++++++
 tb/tb_gbe_tx_packetizer.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gbe_tx_packetizer.sv
// Buffers spectrometer words in a FIFO and emits fixed-size UDP frames (header + payload) to a 10GbE core.
// Optional frame counter: define GBE_TX_PKT_CNT_EN to enable pkt_count; otherwise it is tied to 0.
module gbe_tx_packetizer #(
  parameter int PAYLOAD_WORDS = 128,
  parameter int FIFO_AWIDTH   = 9
) (
  input  logic        user_clk,
  input  logic        user_rst_n,
  input  logic        enable,
  input  logic [63:0] din,
  input  logic        din_valid,
  input  logic [31:0] dest_ip,
  input  logic [15:0] dest_port,
  input  logic        tx_afull,
  output logic [63:0] tx_data,
  output logic        tx_valid,
  output logic        tx_end_of_frame,
  output logic [31:0] tx_dest_ip,
  output logic [15:0] tx_dest_port,
  output logic        overflow,
  output logic [31:0] pkt_count
);

  localparam int DEPTH = 1 << FIFO_AWIDTH;
  localparam int BW    = $clog2(PAYLOAD_WORDS);

  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} state_t;

  state_t                 state;
  logic [63:0]            mem [DEPTH];
  logic [FIFO_AWIDTH-1:0] wr_ptr;
  logic [FIFO_AWIDTH-1:0] rd_ptr;
  logic [FIFO_AWIDTH:0]   count;
  logic [BW-1:0]          beat;
  logic [47:0]            seq;
  logic                   fifo_full;
  logic                   rd_en;
  logic                   wr_en;
  logic                   start;
  logic                   last_beat;

  // A word is popped in HEADER (first payload word) and on every PAYLOAD cycle, so
  // the synchronous read lands on tx_data exactly when it is due -- no bubbles.
  assign fifo_full = (count == (FIFO_AWIDTH+1)'(DEPTH));
  assign rd_en     = (state != IDLE);
  assign wr_en     = din_valid && (!fifo_full || rd_en);
  assign last_beat = (state == PAYLOAD) && (beat == BW'(PAYLOAD_WORDS - 1));
  // tx_valid is still high on the end-of-frame beat, which forces one idle cycle.
  assign start     = (state == IDLE) && enable && !tx_afull && !tx_valid &&
                     (count >= (FIFO_AWIDTH+1)'(PAYLOAD_WORDS));

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (din_valid && !wr_en) overflow <= 1'b1;
    end
  end

  // NOTE: the storage array has no reset; emptying the FIFO only needs the pointers and count cleared.
  always_ff @(posedge user_clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state           <= IDLE;
      beat            <= '0;
      seq             <= '0;
      tx_data         <= '0;
      tx_valid        <= 1'b0;
      tx_end_of_frame <= 1'b0;
      tx_dest_ip      <= '0;
      tx_dest_port    <= '0;
    end else begin
      tx_valid        <= 1'b0;
      tx_end_of_frame <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state        <= HEADER;
            tx_valid     <= 1'b1;
            tx_data      <= {seq, 16'(PAYLOAD_WORDS)};
            tx_dest_ip   <= dest_ip;
            tx_dest_port <= dest_port;
          end
        end
        HEADER: begin
          state    <= PAYLOAD;
          tx_valid <= 1'b1;
          tx_data  <= mem[rd_ptr];
          beat     <= BW'(1);
        end
        PAYLOAD: begin
          tx_valid <= 1'b1;
          tx_data  <= mem[rd_ptr];
          beat     <= beat + 1'b1;
          if (last_beat) begin
            tx_end_of_frame <= 1'b1;
            seq             <= seq + 1'b1;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef GBE_TX_PKT_CNT_EN
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n)    pkt_count <= '0;
    else if (last_beat) pkt_count <= pkt_count + 1'b1;
  end
`else
  assign pkt_count = '0;
`endif

endmodule

// File: tb/tb_gbe_tx_packetizer.sv
// Self-checking bench for gbe_tx_packetizer: random payloads, a queue model of the FIFO and
// a frame-level scoreboard derived from the framing rules.
module tb_gbe_tx_packetizer;

  localparam int P     = 128;
  localparam int DEPTH = 512;

  logic        user_clk = 1'b0;
  logic        user_rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [63:0] din = '0;
  logic        din_valid = 1'b0;
  logic [31:0] dest_ip = '0;
  logic [15:0] dest_port = '0;
  logic        tx_afull = 1'b0;
  logic [63:0] tx_data;
  logic        tx_valid;
  logic        tx_end_of_frame;
  logic [31:0] tx_dest_ip;
  logic [15:0] tx_dest_port;
  logic        overflow;
  logic [31:0] pkt_count;

  gbe_tx_packetizer #(.PAYLOAD_WORDS(P), .FIFO_AWIDTH(9)) dut (
    .user_clk        (user_clk),
    .user_rst_n      (user_rst_n),
    .enable          (enable),
    .din             (din),
    .din_valid       (din_valid),
    .dest_ip         (dest_ip),
    .dest_port       (dest_port),
    .tx_afull        (tx_afull),
    .tx_data         (tx_data),
    .tx_valid        (tx_valid),
    .tx_end_of_frame (tx_end_of_frame),
    .tx_dest_ip      (tx_dest_ip),
    .tx_dest_port    (tx_dest_port),
    .overflow        (overflow),
    .pkt_count       (pkt_count)
  );

  always #5 user_clk = ~user_clk;

  typedef struct {
    logic [63:0] data;
    logic        eof;
    logic [31:0] ip;
    logic [15:0] port;
    int          cyc;
  } beat_t;

  beat_t       rx_q[$];
  logic [63:0] model_q[$];
  logic        exp_ovf;
  logic [47:0] exp_seq;
  int          frames_since_reset;
  int          last_eof_cyc;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  always @(posedge user_clk) cyc <= cyc + 1;

  // Record every valid output beat, sampled mid-cycle.
  always @(negedge user_clk) begin
    if (user_rst_n && tx_valid)
      rx_q.push_back('{data: tx_data, eof: tx_end_of_frame, ip: tx_dest_ip,
                       port: tx_dest_port, cyc: cyc});
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] exp_pkt();
`ifdef GBE_TX_PKT_CNT_EN
    return 32'(frames_since_reset);
`else
    return 32'd0;
`endif
  endfunction

  task automatic apply_reset();
    user_rst_n = 1'b0;
    din_valid  = 1'b0;
    repeat (3) @(negedge user_clk);
    user_rst_n = 1'b1;
    rx_q.delete();
    model_q.delete();
    exp_ovf            = 1'b0;
    exp_seq            = '0;
    frames_since_reset = 0;
    last_eof_cyc       = -1000;
  endtask

  // FIFO model: a word is kept while fewer than DEPTH are buffered, otherwise it is lost.
  task automatic drive_word(input logic [63:0] w);
    @(negedge user_clk);
    din       = w;
    din_valid = 1'b1;
    if (model_q.size() < DEPTH) model_q.push_back(w);
    else                        exp_ovf = 1'b1;
  endtask

  task automatic idle_input();
    @(negedge user_clk);
    din_valid = 1'b0;
  endtask

  task automatic feed_random(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(3) == 0) idle_input();
      drive_word({$urandom, $urandom});
    end
    idle_input();
  endtask

  task automatic wait_beats(input int n, input int budget, input string tag);
    int k = 0;
    while (rx_q.size() < n && k < budget) begin
      @(negedge user_clk);
      #1;
      k++;
    end
    total++;
    if (rx_q.size() < n) begin
      bad++;
      $display("FAIL %s: beats seen=%0d expected=%0d", tag, rx_q.size(), n);
    end
  endtask

  // Pops one header + P payload beats and compares them with the FIFO model.
  task automatic take_frame(input logic [31:0] ip, input logic [15:0] port, input string tag);
    beat_t       b;
    logic [63:0] w;
    int          prev;
    total++;
    if (rx_q.size() < P + 1) begin
      bad++;
      $display("FAIL %s_len: beats=%0d expected=%0d", tag, rx_q.size(), P + 1);
      return;
    end
    b = rx_q.pop_front();
    total++;
    if (b.data !== {exp_seq, 16'(P)} || b.eof !== 1'b0) begin
      bad++;
      $display("FAIL %s_header: got %h eof=%b expected %h eof=0", tag, b.data, b.eof, {exp_seq, 16'(P)});
    end
    total++;
    if (b.ip !== ip || b.port !== port) begin
      bad++;
      $display("FAIL %s_dest: got %h:%0d expected %h:%0d", tag, b.ip, b.port, ip, port);
    end
    total++;
    if (b.cyc - last_eof_cyc < 2) begin
      bad++;
      $display("FAIL %s_gap: header %0d cycles after eof, expected >=2", tag, b.cyc - last_eof_cyc);
    end
    prev = b.cyc;
    for (int i = 0; i < P; i++) begin
      b = rx_q.pop_front();
      w = 'x;
      if (model_q.size() > 0) w = model_q.pop_front();
      total++;
      if (b.data !== w || b.eof !== (i == P - 1) || b.cyc != prev + 1 || b.ip !== ip || b.port !== port) begin
        bad++;
        $display("FAIL %s_word%0d: got %h eof=%b cyc=%0d ip=%h expected %h eof=%b cyc=%0d ip=%h",
                 tag, i, b.data, b.eof, b.cyc, b.ip, w, (i == P - 1), prev + 1, ip);
      end
      prev = b.cyc;
    end
    last_eof_cyc = prev;
    exp_seq++;
    frames_since_reset++;
  endtask

  task automatic expect_quiet(input int cycles, input string tag);
    repeat (cycles) @(negedge user_clk);
    #1;
    total++;
    if (rx_q.size() != 0) begin
      bad++;
      $display("FAIL %s: %0d unexpected beats, expected 0", tag, rx_q.size());
    end
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge user_clk);
    #1;
    total += 7;
    if (tx_valid !== 1'b0)        begin bad++; $display("FAIL rst_valid: got %b expected 0", tx_valid); end
    if (tx_end_of_frame !== 1'b0) begin bad++; $display("FAIL rst_eof: got %b expected 0", tx_end_of_frame); end
    if (tx_data !== 64'd0)        begin bad++; $display("FAIL rst_data: got %h expected 0", tx_data); end
    if (tx_dest_ip !== 32'd0)     begin bad++; $display("FAIL rst_ip: got %h expected 0", tx_dest_ip); end
    if (tx_dest_port !== 16'd0)   begin bad++; $display("FAIL rst_port: got %h expected 0", tx_dest_port); end
    if (overflow !== 1'b0)        begin bad++; $display("FAIL rst_ovf: got %b expected 0", overflow); end
    if (pkt_count !== 32'd0)      begin bad++; $display("FAIL rst_cnt: got %0d expected 0", pkt_count); end
  endtask

  task automatic test_basic();
    dest_ip   = 32'h0A00_0002;
    dest_port = 16'd7148;
    enable    = 1'b1;
    for (int i = 0; i < P; i++) drive_word(64'(i));
    idle_input();
    wait_beats(P + 1, 400, "basic_wait");
    take_frame(32'h0A00_0002, 16'd7148, "basic");
    total++;
    if (pkt_count !== exp_pkt()) begin
      bad++;
      $display("FAIL basic_cnt: got %0d expected %0d", pkt_count, exp_pkt());
    end
    expect_quiet(20, "basic_quiet");
  endtask

  task automatic test_back_to_back();
    apply_reset();
    feed_random(2 * P, 1'b0);
    wait_beats(2 * (P + 1), 600, "b2b_wait");
    take_frame(dest_ip, dest_port, "b2b_f0");
    take_frame(dest_ip, dest_port, "b2b_f1");
    total++;
    if (pkt_count !== exp_pkt()) begin
      bad++;
      $display("FAIL b2b_cnt: got %0d expected %0d", pkt_count, exp_pkt());
    end
  endtask

  task automatic test_afull();
    dest_port = 16'($urandom_range(1024, 65535));
    tx_afull  = 1'b1;
    feed_random(300, 1'b1);
    expect_quiet(20, "afull_hold");
    tx_afull = 1'b0;
    wait_beats(2 * (P + 1), 600, "afull_wait");
    take_frame(dest_ip, dest_port, "afull_f0");
    take_frame(dest_ip, dest_port, "afull_f1");
    expect_quiet(300, "afull_residue");
    feed_random(P - 44, 1'b1);
    wait_beats(P + 1, 600, "afull_tail_wait");
    take_frame(dest_ip, dest_port, "afull_tail");
  endtask

  task automatic test_dest_change();
    dest_ip = 32'h0A00_0002;
    fork
      feed_random(2 * P, 1'b0);
      begin
        wait_beats(40, 400, "dest_mid_wait");
        dest_ip  = 32'h0A00_0003;
        tx_afull = 1'b1;
        enable   = 1'b0;
        repeat (20) @(negedge user_clk);
        tx_afull = 1'b0;
        enable   = 1'b1;
      end
    join
    wait_beats(2 * (P + 1), 700, "dest_wait");
    take_frame(32'h0A00_0002, dest_port, "dest_f0");
    take_frame(32'h0A00_0003, dest_port, "dest_f1");
  endtask

  task automatic test_overflow();
    logic [63:0] extra;
    enable = 1'b0;
    for (int i = 0; i < 600; i++) begin
      drive_word({$urandom, $urandom});
      @(posedge user_clk);
      #1;
      total++;
      if (overflow !== exp_ovf) begin
        bad++;
        $display("FAIL ovf_word%0d: got %b expected %b", i + 1, overflow, exp_ovf);
      end
    end
    @(negedge user_clk);
    din_valid = 1'b0;
    enable    = 1'b1;
    // While the header is on the wire the FIFO is full and being read: a write must be accepted.
    wait_beats(1, 50, "ovf_start");
    extra     = {$urandom, $urandom};
    din       = extra;
    din_valid = 1'b1;
    model_q.push_back(extra);
    idle_input();
    wait_beats(4 * (P + 1), 2500, "ovf_drain_wait");
    for (int f = 0; f < 4; f++) take_frame(dest_ip, dest_port, "ovf_drain");
    total++;
    if (overflow !== 1'b1) begin
      bad++;
      $display("FAIL ovf_sticky: got %b expected 1", overflow);
    end
    expect_quiet(200, "ovf_residue");
    feed_random(P - 1, 1'b1);
    wait_beats(P + 1, 600, "ovf_tail_wait");
    take_frame(dest_ip, dest_port, "ovf_fullrd");
  endtask

  task automatic test_reset_mid_frame();
    int eofs;
    feed_random(P, 1'b0);
    wait_beats(62, 400, "mid_wait");
    user_rst_n = 1'b0;
    #1;
    total += 2;
    if (tx_valid !== 1'b0)        begin bad++; $display("FAIL mid_valid: got %b expected 0", tx_valid); end
    if (tx_end_of_frame !== 1'b0) begin bad++; $display("FAIL mid_eof: got %b expected 0", tx_end_of_frame); end
    eofs = 0;
    foreach (rx_q[i]) if (rx_q[i].eof) eofs++;
    total++;
    if (eofs != 0 || rx_q.size() != 62) begin
      bad++;
      $display("FAIL mid_abandon: beats=%0d eofs=%0d expected beats=62 eofs=0", rx_q.size(), eofs);
    end
    apply_reset();
    total += 2;
    if (overflow !== 1'b0)   begin bad++; $display("FAIL mid_ovf: got %b expected 0", overflow); end
    if (pkt_count !== 32'd0) begin bad++; $display("FAIL mid_cnt: got %0d expected 0", pkt_count); end
    expect_quiet(50, "mid_quiet");
    dest_ip = $urandom;
    feed_random(P, 1'b1);
    wait_beats(P + 1, 600, "mid_after_wait");
    take_frame(dest_ip, dest_port, "mid_after");
    total++;
    if (pkt_count !== exp_pkt()) begin
      bad++;
      $display("FAIL mid_cnt_after: got %0d expected %0d", pkt_count, exp_pkt());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_afull();
    test_dest_change();
    test_overflow();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
